// File: rtl/apb_reg_slave_pkg.sv
// Shared types and constants for the APB image register slave.
package apb_reg_slave_pkg;

    // APB phase tracker states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Control register address; image words live at 1..Num_Words
    localparam int ADDR_CTRL = 0;

    // Control write bit
    localparam int CTRL_START = 0;

    // Status read bits
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_RESULT = 2;
    localparam int STAT_PERR   = 3;

endpackage

// File: rtl/apb_reg_slave_image_ram.sv
// Image word store: one write port, two registered read ports (APB, core).
// Valid word addresses are 1..DEPTH; anything else reads as zero.
module image_ram #(
    parameter int W     = 24,
    parameter int AW    = 13,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          a_en,
    input  logic [AW-1:0] a_addr,
    output logic [W-1:0]  a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [W-1:0]  b_rdata
);

    logic [W-1:0] mem [1:DEPTH];

    function automatic logic in_range(input logic [AW-1:0] addr);
        return (addr != '0) && (int'(addr) <= DEPTH);
    endfunction

    // Storage is deliberately not reset so image data survives rst
    always_ff @(posedge clk) begin
        if (we && in_range(waddr))
            mem[waddr] <= wdata;
    end

    // APB port holds its word until the next enabled read; core port reads every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en)
                a_rdata <= in_range(a_addr) ? mem[a_addr] : '0;
            b_rdata <= in_range(b_addr) ? mem[b_addr] : '0;
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave exposing a control/status register at address 0 and an image RAM
// above it; hands off to a compute core via start/busy/core_done.
module apb_reg_slave
    import apb_reg_slave_pkg::*;
#(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12,
    parameter int Num_Words       = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [Amba_Addr_Depth:0] PADDR,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [Amba_Word-1:0]     PWDATA,
    output logic [Amba_Word-1:0]     PRDATA,
    input  logic [Amba_Addr_Depth:0] core_raddr,
    output logic [Amba_Word-1:0]     core_rdata,
    output logic                     start,
    output logic                     busy,
    input  logic                     core_done,
    input  logic                     core_result
);

    localparam int AW = Amba_Addr_Depth + 1;
    localparam logic [AW-1:0] CTRL_A = AW'(ADDR_CTRL);

    apb_state_e state, nstate;
    logic perr_set, wr_fire, rd_fire;
    logic done, result, proto_err;
    logic done_evt, start_fire, is_ctrl, img_we;
    logic rd_img_q;
    logic [Amba_Word-1:0] ctrl_rdata_q, status, ram_apb_q;

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next phase plus commit strobes; commits happen only on SETUP->ACCESS.
    // PENABLE from another slave's transfer is normal, so only a selected
    // access phase with no setup counts as a protocol error.
    always_comb begin
        nstate   = state;
        perr_set = 1'b0;
        wr_fire  = 1'b0;
        rd_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE)     nstate = SETUP;
                else if (PSEL && PENABLE) perr_set = 1'b1;
            end
            SETUP: begin
                if (!PSEL) nstate = IDLE;
                else if (PENABLE) begin
                    nstate  = ACCESS;
                    wr_fire = PWRITE;
                    rd_fire = !PWRITE;
                end
            end
            ACCESS: begin
                if (PSEL && !PENABLE) nstate = SETUP;
                else                  nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    // Decode of committed accesses; a completion on the same edge beats a start
    always_comb begin
        is_ctrl    = (PADDR == CTRL_A);
        done_evt   = core_done && busy;
        start_fire = wr_fire && is_ctrl && PWDATA[CTRL_START] && !busy && !done_evt;
        img_we     = wr_fire && !is_ctrl && !busy && !rst;
    end

    // Status word as seen by an address-0 read
    always_comb begin
        status              = '0;
        status[STAT_BUSY]   = busy;
        status[STAT_DONE]   = done;
        status[STAT_RESULT] = result;
        status[STAT_PERR]   = proto_err;
    end

    // Core handshake and sticky error; result is cleared by a new start so
    // it only reads as meaningful alongside done
    always_ff @(posedge clk) begin
        if (rst) begin
            start     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            start <= start_fire;
            if (done_evt) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= core_result;
            end else if (start_fire) begin
                busy   <= 1'b1;
                done   <= 1'b0;
                result <= 1'b0;
            end
            if (perr_set)                proto_err <= 1'b1;
            else if (rd_fire && is_ctrl) proto_err <= 1'b0;
        end
    end

    // Read-data source select; image words come from the RAM's own output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_img_q     <= 1'b0;
            ctrl_rdata_q <= '0;
        end else if (rd_fire) begin
            rd_img_q     <= !is_ctrl;
            ctrl_rdata_q <= is_ctrl ? status : '0;
        end
    end

    assign PRDATA = rd_img_q ? ram_apb_q : ctrl_rdata_q;

    image_ram #(
        .W     (Amba_Word),
        .AW    (AW),
        .DEPTH (Num_Words)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (img_we),
        .waddr   (PADDR),
        .wdata   (PWDATA),
        .a_en    (rd_fire),
        .a_addr  (PADDR),
        .a_rdata (ram_apb_q),
        .b_addr  (core_raddr),
        .b_rdata (core_rdata)
    );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: register map, start/done handshake,
// protocol-error flag, range checks and reset behaviour.
module tb_apb_reg_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [23:0] PWDATA, PRDATA;
    logic [12:0] core_raddr;
    logic [23:0] core_rdata;
    logic        start, busy, core_done, core_result;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int cnt0;
    logic [23:0] rd;

    always #5 clk = ~clk;

    apb_reg_slave dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .core_raddr(core_raddr), .core_rdata(core_rdata), .start(start),
        .busy(busy), .core_done(core_done), .core_result(core_result)
    );

    // Count high cycles of start, sampled mid-cycle
    always @(negedge clk) if (start) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [12:0] a, input logic [23:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Returns PRDATA as seen in the access cycle
    task automatic apb_read(input logic [12:0] a, output logic [23:0] d);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(negedge clk);
        PENABLE = 1'b1;
        @(negedge clk);
        d = PRDATA;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse_done(input logic r);
        @(negedge clk);
        core_done = 1'b1; core_result = r;
        @(negedge clk);
        core_done = 1'b0; core_result = 1'b0;
    endtask

    initial begin
        rst = 1'b1; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
        core_raddr = '0; core_done = 0; core_result = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_prdata", PRDATA, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        apb_read(13'd0, rd); chk("rst_status", rd, 24'h0);

        // Basic image write/read
        apb_write(13'd5, 24'hABCDEF);
        apb_read(13'd5, rd); chk("rd_addr5", rd, 24'hABCDEF);

        // Core read port, one-cycle latency
        apb_write(13'd7, 24'h111111);
        @(negedge clk); core_raddr = 13'd7;
        @(negedge clk); chk("core_rd7", core_rdata, 24'h111111);

        // Start: one-cycle pulse, busy, image locked
        cnt0 = start_cnt;
        apb_write(13'd0, 24'h1);
        chk("busy_after_start", busy, 1);
        repeat (3) @(negedge clk);
        chk("start_one_cycle", start_cnt - cnt0, 1);
        apb_read(13'd0, rd); chk("status_busy", rd, 24'h1);
        apb_write(13'd7, 24'h222222);
        apb_read(13'd7, rd); chk("locked_addr7", rd, 24'h111111);
        chk("core_rd7_busy", core_rdata, 24'h111111);
        cnt0 = start_cnt;
        apb_write(13'd0, 24'h1);
        repeat (2) @(negedge clk);
        chk("start_while_busy", start_cnt - cnt0, 0);

        // Completion with cat result, then restart
        pulse_done(1'b1);
        apb_read(13'd0, rd); chk("status_done", rd, 24'h6);
        cnt0 = start_cnt;
        apb_write(13'd0, 24'h1);
        repeat (2) @(negedge clk);
        chk("restart_pulse", start_cnt - cnt0, 1);
        apb_read(13'd0, rd); chk("status_restart", rd, 24'h1);

        // Protocol error: access phase with no setup is not committed
        pulse_done(1'b0);
        apb_write(13'd9, 24'h999999);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 13'd9; PWDATA = 24'h555555;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0;
        apb_read(13'd9, rd); chk("perr_no_write", rd, 24'h999999);
        apb_read(13'd0, rd); chk("perr_first", rd, 24'hA);
        apb_read(13'd0, rd); chk("perr_cleared", rd, 24'h2);

        // Address range boundaries
        apb_write(13'd4097, 24'h123456);
        apb_read(13'd4097, rd); chk("oor_read", rd, 24'h0);
        apb_write(13'd4096, 24'h0F0F0F);
        apb_read(13'd4096, rd); chk("last_word", rd, 24'h0F0F0F);
        apb_read(13'd5, rd); chk("addr5_kept", rd, 24'hABCDEF);

        // Reset in the middle of a transfer: nothing committed
        apb_write(13'd6, 24'h666666);
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 13'd6; PWDATA = 24'h777777;
        @(negedge clk);
        PENABLE = 1'b1; rst = 1'b1;
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; rst = 1'b0;
        apb_read(13'd6, rd); chk("rst_mid_xfer", rd, 24'h666666);

        // Reset while busy, late completion dropped, image survives
        apb_write(13'd0, 24'h1);
        chk("busy_before_rst", busy, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("busy_after_rst", busy, 0);
        pulse_done(1'b1);
        chk("busy_late_done", busy, 0);
        apb_read(13'd0, rd); chk("status_late_done", rd, 24'h0);
        apb_read(13'd5, rd); chk("ram_survives_rst", rd, 24'hABCDEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter Amba_Word, default 24: APB data width; one word holds three 8-bit pixels.
REQ-002 Parameter Amba_Addr_Depth, default 12: APB address is Amba_Addr_Depth+1 bits wide.
REQ-003 Parameter Num_Words, default 4096: image words stored at addresses 1..Num_Words.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk  in  1  system clock; all state changes on its rising edge.
REQ-006 Port rst  in  1  synchronous active-high reset.
REQ-007 Port PADDR  in  Amba_Addr_Depth+1  APB address.
REQ-008 Port PSEL  in  1  APB select.
REQ-009 Port PENABLE  in  1  APB access-phase strobe.
REQ-010 Port PWRITE  in  1  1 = write, 0 = read.
REQ-011 Port PWDATA  in  Amba_Word  write data.
REQ-012 Port PRDATA  out  Amba_Word  read data, registered.
REQ-013 Port core_raddr  in  Amba_Addr_Depth+1  compute-core image read address.
REQ-014 Port core_rdata  out  Amba_Word  image word at core_raddr; 1-cycle latency.
REQ-015 Port start  out  1  one-cycle start pulse to the compute core.
REQ-016 Port busy  out  1  core computing; image writes locked.
REQ-017 Port core_done  in  1  one-cycle completion pulse from the core.
REQ-018 Port core_result  in  1  cat/not-cat result, valid with core_done.

Function
REQ-019 The phase FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-020 IDLE->SETUP on PSEL & !PENABLE.
REQ-021 SETUP->ACCESS on PSEL & PENABLE.
REQ-022 SETUP->IDLE on !PSEL.
REQ-023 ACCESS->SETUP on PSEL & !PENABLE (back-to-back transfer); ACCESS->IDLE otherwise.
REQ-024 PENABLE=1 in IDLE (no setup phase) SHALL be ignored, set sticky proto_err and leave the FSM in IDLE.
REQ-025 A write SHALL commit on the SETUP->ACCESS edge only, exactly once per transfer, even if PENABLE is held.
REQ-026 Address 0, control: PWDATA[0]=1 with busy=0 -> start=1 for one cycle next cycle, busy=1, done cleared.
REQ-027 Address 0, control: PWDATA[0]=1 with busy=1 is ignored; PWDATA[0]=0 has no effect.
REQ-028 Address 1..Num_Words with busy=0: the word is written to image RAM at that address.
REQ-029 Image writes with busy=1 SHALL be dropped.
REQ-030 Writes to addresses above Num_Words SHALL be dropped.
REQ-031 Reads: PRDATA SHALL be loaded on the SETUP->ACCESS edge and held until the next read.
REQ-032 Read of address 0 returns status {0..., proto_err[3], result[2], done[1], busy[0]}.
REQ-033 Read of image addresses returns the stored word; read of out-of-range addresses returns 0.
REQ-034 core_done while busy: busy->0, done->1, result<=core_result; core_done while !busy is ignored.
REQ-035 core_done and a start write on the same edge: done is processed and the start is ignored.
REQ-036 A read of address 0 SHALL clear proto_err after returning its value.
REQ-037 core_rdata SHALL be registered and return the word for core_raddr with 1-cycle latency, regardless of busy.

Reset
REQ-038 rst SHALL force: FSM to IDLE; PRDATA, core_rdata, start, busy, done, result and proto_err to 0.
REQ-039 Image RAM contents SHALL NOT be cleared by rst.
REQ-040 rst mid-transfer SHALL abort the transfer with no write committed; rst while busy drops any later core_done.

Structure
REQ-041 Shared package holds the FSM state enum, the control/status bit indices and the ADDR_CTRL=0 constant.
REQ-042 The image RAM SHALL be sub-module image_ram (one write port, two registered read ports: APB and core).

Verification
REQ-043 Write 0xABCDEF to addr 5, then read addr 5 -> PRDATA=0xABCDEF in the ACCESS cycle.
REQ-044 Write 1 to addr 0 -> start high exactly one cycle, status read=0x1; then write addr 7 -> RAM addr 7 unchanged.
REQ-045 Pulse core_done with core_result=1 -> status read=0x6; then write 1 to addr 0 -> new start pulse, status=0x1.
REQ-046 PENABLE without a setup phase -> no write committed; status bit3=1 on the first read, 0 on the second.
REQ-047 Write 0x123456 to addr 4097 -> dropped; read addr 4097 -> 0.
REQ-048 rst mid-busy, then core_done -> busy=0, done=0; image data written before rst still reads back.
